// File: rtl/vend_pkg.sv
// Shared definitions for the coin pulse conditioner: emission states,
// coin channel indices, the 3-bit coin vector type and the fixed
// N > D > Q grant priority.
`timescale 1ns/1ps
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } emit_state_e;

   localparam int COIN_N = 0;
   localparam int COIN_D = 1;
   localparam int COIN_Q = 2;

   typedef logic [2:0] coin_vec_t;

   // One-hot grant of the highest-priority requesting coin (nickel first).
   function automatic coin_vec_t coin_priority(input coin_vec_t req);
      coin_vec_t g;
      g = '0;
      if (req[COIN_N]) begin
         g[COIN_N] = 1'b1;
      end else if (req[COIN_D]) begin
         g[COIN_D] = 1'b1;
      end else if (req[COIN_Q]) begin
         g[COIN_Q] = 1'b1;
      end
      return g;
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser followed by a debouncer: the output level only
// changes after the synchronised input has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles.
`timescale 1ns/1ps
module coin_debounce
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Bring the asynchronous sensor line into the clock domain.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive disagreeing cycles; toggle the level once the run is long enough.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Debounce counter and accepted level registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin pulse conditioner: debounces the three coin sensors and the
// soda/diet switch, latches each accepted coin as a pending request and
// emits pending coins one at a time as single-cycle pulses, separated by
// GAP_CYCLES idle cycles and held off while vend_busy is high.
// Optional build macro COIN_COUNT_EN adds saturating 8-bit per-type
// counters of emitted pulses (cnt_n, cnt_d, cnt_q).
`timescale 1ns/1ps
module coin_pulse_conditioner
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int GAP_CYCLES      = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_n_raw,
   input  logic       coin_d_raw,
   input  logic       coin_q_raw,
   input  logic       sel_raw,
   input  logic       vend_busy,
   output logic       N_in,
   output logic       D_in,
   output logic       Q_in,
   output logic       SodaDiet_Sel,
`ifdef COIN_COUNT_EN
   output logic       coin_lost,
   output logic [7:0] cnt_n,
   output logic [7:0] cnt_d,
   output logic [7:0] cnt_q
`else
   output logic       coin_lost
`endif
);

   localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   coin_vec_t         lvl;
   coin_vec_t         lvl_prev_q;
   coin_vec_t         rise;
   coin_vec_t         pending_q;
   coin_vec_t         pending_d;
   coin_vec_t         pulse_q;
   coin_vec_t         pulse_d;
   coin_vec_t         grant;
   logic              sel_lvl;
   logic              can_grant;
   logic              lost_q;
   logic              lost_d;
   emit_state_e       state_q;
   emit_state_e       state_d;
   logic [GAP_W-1:0]  gap_cnt_q;
   logic [GAP_W-1:0]  gap_cnt_d;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
      .clk_i   (clk),
      .rst_i   (reset),
      .raw_i   (coin_n_raw),
      .level_o (lvl[COIN_N])
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
      .clk_i   (clk),
      .rst_i   (reset),
      .raw_i   (coin_d_raw),
      .level_o (lvl[COIN_D])
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_q (
      .clk_i   (clk),
      .rst_i   (reset),
      .raw_i   (coin_q_raw),
      .level_o (lvl[COIN_Q])
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
      .clk_i   (clk),
      .rst_i   (reset),
      .raw_i   (sel_raw),
      .level_o (sel_lvl)
   );

   assign rise = lvl & ~lvl_prev_q;

   // Emission sequencing plus pending/lost bookkeeping. The last GAP cycle
   // (or PULSE when there is no gap) makes the same grant decision as IDLE,
   // so consecutive pulses are exactly GAP_CYCLES idle cycles apart.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      grant     = '0;
      can_grant = 1'b0;
      case (state_q)
         IDLE: begin
            can_grant = 1'b1;
         end
         PULSE: begin
            gap_cnt_d = '0;
            if (GAP_CYCLES == 0) begin
               can_grant = 1'b1;
            end else begin
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               gap_cnt_d = '0;
               can_grant = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (can_grant) begin
         if (!vend_busy && (pending_q != '0)) begin
            grant   = coin_priority(pending_q);
            state_d = PULSE;
         end else begin
            state_d = IDLE;
         end
      end
      pulse_d   = grant;
      // A fresh edge on the channel being granted re-arms its pending bit.
      pending_d = (pending_q & ~grant) | rise;
      lost_d    = lost_q | (|(rise & pending_q & ~grant));
   end

   // Emission state, gap counter, pending coins, registered pulse outputs and sticky loss flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         gap_cnt_q  <= '0;
         pending_q  <= '0;
         pulse_q    <= '0;
         lvl_prev_q <= '0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         pending_q  <= pending_d;
         pulse_q    <= pulse_d;
         lvl_prev_q <= lvl;
         lost_q     <= lost_d;
      end
   end

   assign N_in         = pulse_q[COIN_N];
   assign D_in         = pulse_q[COIN_D];
   assign Q_in         = pulse_q[COIN_Q];
   assign SodaDiet_Sel = sel_lvl;
   assign coin_lost    = lost_q;

`ifdef COIN_COUNT_EN
   logic [7:0] cnt_n_q;
   logic [7:0] cnt_d_q;
   logic [7:0] cnt_q_q;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Per-type emitted-pulse counters, updated as each pulse is launched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_n_q <= 8'd0;
         cnt_d_q <= 8'd0;
         cnt_q_q <= 8'd0;
      end else begin
         if (grant[COIN_N]) cnt_n_q <= sat_inc(cnt_n_q);
         if (grant[COIN_D]) cnt_d_q <= sat_inc(cnt_d_q);
         if (grant[COIN_Q]) cnt_q_q <= sat_inc(cnt_q_q);
      end
   end

   assign cnt_n = cnt_n_q;
   assign cnt_d = cnt_d_q;
   assign cnt_q = cnt_q_q;
`endif

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner (DEBOUNCE_CYCLES=4, GAP_CYCLES=1):
// directed scenarios with literal expectations plus a randomized run, all
// cross-checked every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_coin_pulse_conditioner;

   localparam int DB = 4;
   localparam int GP = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic coin_n_raw = 1'b0;
   logic coin_d_raw = 1'b0;
   logic coin_q_raw = 1'b0;
   logic sel_raw = 1'b0;
   logic vend_busy = 1'b0;
   logic N_in, D_in, Q_in, SodaDiet_Sel, coin_lost;

   int n_checks = 0;
   int n_errors = 0;

   coin_pulse_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .GAP_CYCLES(GP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .coin_n_raw   (coin_n_raw),
      .coin_d_raw   (coin_d_raw),
      .coin_q_raw   (coin_q_raw),
      .sel_raw      (sel_raw),
      .vend_busy    (vend_busy),
      .N_in         (N_in),
      .D_in         (D_in),
      .Q_in         (Q_in),
      .SodaDiet_Sel (SodaDiet_Sel),
      .coin_lost    (coin_lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each line's accepted level flips once the last DB synchronised samples
   // (raw delayed by two edges) all disagree with it. An accepted coin is
   // emitted no earlier than 1+GP edges after the previous grant.
   logic [15:0] hist_m [4];
   logic [3:0]  lvl_m = '0;
   logic [3:0]  lvl_old_m = '0;
   logic [2:0]  pend_m = '0;
   logic [2:0]  pulse_m = '0;
   logic        lost_m = 1'b0;
   int          edge_m = 0;
   int          next_ok_m = 0;

   always @(posedge clk) begin : model_blk
      logic [3:0] raw_now;
      logic [2:0] rise;
      logic [2:0] g;
      logic       all_diff;
      if (reset) begin
         for (int c = 0; c < 4; c++) hist_m[c] = '0;
         lvl_m = '0; lvl_old_m = '0; pend_m = '0; pulse_m = '0;
         lost_m = 1'b0; edge_m = 0; next_ok_m = 0;
      end else begin
         raw_now = {sel_raw, coin_q_raw, coin_d_raw, coin_n_raw};
         rise = lvl_m[2:0] & ~lvl_old_m[2:0];
         g = 3'b000;
         if (edge_m >= next_ok_m && !vend_busy && pend_m != 3'b000) begin
            if (pend_m[0])      g = 3'b001;
            else if (pend_m[1]) g = 3'b010;
            else                g = 3'b100;
            next_ok_m = edge_m + 1 + GP;
         end
         if ((rise & pend_m & ~g) != 3'b000) lost_m = 1'b1;
         pend_m = (pend_m & ~g) | rise;
         pulse_m = g;
         lvl_old_m = lvl_m;
         for (int c = 0; c < 4; c++) begin
            hist_m[c] = {hist_m[c][14:0], raw_now[c]};
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
               if (hist_m[c][j] == lvl_m[c]) all_diff = 1'b0;
            if (all_diff) lvl_m[c] = ~lvl_m[c];
         end
         edge_m++;
      end
      #1;
      chk("model_outputs", {3'b000, SodaDiet_Sel, coin_lost, Q_in, D_in, N_in},
          {3'b000, lvl_m[3], lost_m, pulse_m[2], pulse_m[1], pulse_m[0]});
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int np;
      int hold [4];
      logic [3:0] rv;

      // reset state
      reset = 1'b1;
      tick(); tick();
      chk("reset_pulses", {5'b0, Q_in, D_in, N_in}, 8'h00);
      chk("reset_sel", {7'b0, SodaDiet_Sel}, 8'h00);
      chk("reset_lost", {7'b0, coin_lost}, 8'h00);
      reset = 1'b0;
      repeat (3) tick();

      // select switch: level follows after 1+DB edges
      sel_raw = 1'b1;
      tick();
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 4) chk("sel_before", {7'b0, SodaDiet_Sel}, 8'h00);
         if (k == 5) chk("sel_after", {7'b0, SodaDiet_Sel}, 8'h01);
      end

      // single nickel: pulse only at cycle 7
      coin_n_raw = 1'b1;
      tick();
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("nickel_c%0d", k), {7'b0, N_in}, (k == 7) ? 8'h01 : 8'h00);
      end
      coin_n_raw = 1'b0;
      repeat (10) tick();

      // bouncing dime, then held high
      for (int i = 0; i < 10; i++) begin
         coin_d_raw = (i % 2 == 0);
         tick();
         chk("dime_bounce", {7'b0, D_in}, 8'h00);
      end
      coin_d_raw = 1'b1;
      tick();
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("dime_c%0d", k), {7'b0, D_in}, (k == 7) ? 8'h01 : 8'h00);
      end
      coin_d_raw = 1'b0;
      repeat (12) tick();

      // simultaneous nickel and quarter: serialised with one gap cycle
      coin_n_raw = 1'b1;
      coin_q_raw = 1'b1;
      tick();
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("nq_n_c%0d", k), {7'b0, N_in}, (k == 7) ? 8'h01 : 8'h00);
         chk($sformatf("nq_q_c%0d", k), {7'b0, Q_in}, (k == 9) ? 8'h01 : 8'h00);
      end
      coin_n_raw = 1'b0;
      coin_q_raw = 1'b0;
      repeat (12) tick();

      // quarter held off by vend_busy through cycle 20
      vend_busy  = 1'b1;
      coin_q_raw = 1'b1;
      tick();
      for (int k = 1; k <= 20; k++) begin
         tick();
         chk("busy_hold", {7'b0, Q_in}, 8'h00);
      end
      vend_busy = 1'b0;
      tick();
      chk("busy_release_q", {7'b0, Q_in}, 8'h01);
      tick();
      chk("busy_release_q_off", {7'b0, Q_in}, 8'h00);
      coin_q_raw = 1'b0;
      repeat (12) tick();

      // two nickels while blocked: coin_lost sticks, one pulse afterwards
      chk("lost_initial", {7'b0, coin_lost}, 8'h00);
      vend_busy = 1'b1;
      for (int r = 0; r < 2; r++) begin
         coin_n_raw = 1'b1;
         repeat (8) tick();
         coin_n_raw = 1'b0;
         repeat (8) tick();
      end
      chk("lost_set", {7'b0, coin_lost}, 8'h01);
      vend_busy = 1'b0;
      np = 0;
      repeat (12) begin
         tick();
         np += int'(N_in);
      end
      chk("lost_single_pulse", np[7:0], 8'h01);
      chk("lost_sticky", {7'b0, coin_lost}, 8'h01);

      // async reset mid-GAP with a dime pending
      coin_n_raw = 1'b1;
      coin_d_raw = 1'b1;
      tick();
      repeat (7) tick();
      chk("rst_gap_n_pulse", {7'b0, N_in}, 8'h01);
      tick();
      chk("rst_gap_idle", {6'b0, D_in, N_in}, 8'h00);
      reset = 1'b1;
      coin_n_raw = 1'b0;
      coin_d_raw = 1'b0;
      #1;
      chk("rst_async_lost", {7'b0, coin_lost}, 8'h00);
      chk("rst_async_sel", {7'b0, SodaDiet_Sel}, 8'h00);
      chk("rst_async_pulses", {5'b0, Q_in, D_in, N_in}, 8'h00);
      tick(); tick();
      reset = 1'b0;
      np = 0;
      repeat (15) begin
         tick();
         np += int'(D_in);
      end
      chk("rst_no_dime", np[7:0], 8'h00);

      // quarter held high through reset release
      reset = 1'b1;
      coin_q_raw = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk($sformatf("hold_rst_q_c%0d", k), {7'b0, Q_in}, (k == 7) ? 8'h01 : 8'h00);
      end
      coin_q_raw = 1'b0;
      repeat (10) tick();

      // randomized traffic against the model
      rv = {sel_raw, coin_q_raw, coin_d_raw, coin_n_raw};
      for (int c = 0; c < 4; c++) hold[c] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            if (hold[c] == 0) begin
               rv[c] = ~rv[c];
               hold[c] = $urandom_range(1, 10);
            end else begin
               hold[c]--;
            end
         end
         {sel_raw, coin_q_raw, coin_d_raw, coin_n_raw} = rv;
         vend_busy = ($urandom_range(0, 9) < 3);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
